// File: rtl/muldiv_pkg.sv
// muldiv_pkg: funct3 op codes, FSM state encodings and operand signedness helpers
package muldiv_pkg;
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    function automatic logic rs2_signed(input logic [2:0] op);
        return op == OP_MULH || op == OP_DIV || op == OP_REM;
    endfunction

    function automatic logic rs1_signed(input logic [2:0] op);
        return rs2_signed(op) || op == OP_MULHSU;
    endfunction
endpackage

// File: rtl/div_iter_core.sv
// div_iter_core: restoring radix-2 divider on unsigned magnitudes, one quotient bit per cycle
module div_iter_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quo,
    output logic [XLEN-1:0] rem,
    output logic            done
);
    localparam int CW = $clog2(XLEN);
    logic [XLEN-1:0] quo_q, rem_q, dvs_q;
    logic [CW-1:0]   cnt;
    logic            active;
    logic [XLEN:0]   trial, diff;
    logic            fits;
    assign trial = {rem_q, quo_q[XLEN-1]};
    assign diff  = trial - {1'b0, dvs_q};
    assign fits  = !diff[XLEN];
    assign rem   = fits ? diff[XLEN-1:0] : trial[XLEN-1:0];
    assign quo   = {quo_q[XLEN-2:0], fits};
    assign done  = active && cnt == CW'(XLEN - 1);
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else if (start) begin
            quo_q  <= dividend;
            rem_q  <= '0;
            dvs_q  <= divisor;
            cnt    <= '0;
            active <= 1'b1;
        end else if (active) begin
            quo_q  <= quo;
            rem_q  <= rem;
            cnt    <= cnt + 1'b1;
            active <= !done;
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M multiply/divide unit with valid/ready handshake and kill
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter bit MUL_REG = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    localparam logic [XLEN-1:0] MIN_VAL = XLEN'(1) << (XLEN - 1);
    logic [1:0]        state;
    logic [2:0]        op_q, mop;
    logic [XLEN-1:0]   a_q, b_q, res_q, ma, mb, mul_res;
    logic [XLEN-1:0]   a_mag, b_mag, spec_res, quo, rem, div_res;
    logic [2*XLEN-1:0] mx, my, prod;
    logic              a_neg_q, b_neg_q, a_neg, b_neg;
    logic              idle, accept, div_zero, ovf, special, div_done;

    assign idle      = state == S_IDLE;
    assign accept    = idle && in_valid && !kill;
    assign in_ready  = idle;
    assign busy      = !idle;
    assign out_valid = state == S_DONE;
    assign result    = res_q;

    // Same multiplier serves the accept cycle (MUL_REG=0) and the MUL state (MUL_REG=1)
    assign mop     = idle ? op : op_q;
    assign ma      = idle ? rs1 : a_q;
    assign mb      = idle ? rs2 : b_q;
    assign mx      = {{XLEN{rs1_signed(mop) & ma[XLEN-1]}}, ma};
    assign my      = {{XLEN{rs2_signed(mop) & mb[XLEN-1]}}, mb};
    assign prod    = mx * my;
    assign mul_res = mop == OP_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    assign a_neg    = rs1_signed(op) & rs1[XLEN-1];
    assign b_neg    = rs2_signed(op) & rs2[XLEN-1];
    assign a_mag    = a_neg ? -rs1 : rs1;
    assign b_mag    = b_neg ? -rs2 : rs2;
    assign div_zero = rs2 == '0;
    assign ovf      = rs2_signed(op) && rs1 == MIN_VAL && rs2 == '1;
    assign special  = div_zero || ovf;
    assign spec_res = div_zero ? (op[1] ? rs1 : '1) : (op[1] ? '0 : rs1);
    assign div_res  = op_q[1] ? (a_neg_q ? -rem : rem) : ((a_neg_q ^ b_neg_q) ? -quo : quo);

    div_iter_core #(.XLEN(XLEN)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (accept && op[2] && !special),
        .abort    (kill),
        .dividend (a_mag),
        .divisor  (b_mag),
        .quo      (quo),
        .rem      (rem),
        .done     (div_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            res_q   <= '0;
        end else if (kill) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    op_q    <= op;
                    a_q     <= rs1;
                    b_q     <= rs2;
                    a_neg_q <= a_neg;
                    b_neg_q <= b_neg;
                    if (op[2]) begin
                        if (special) res_q <= spec_res;
                        state <= special ? S_DONE : S_DIV;
                    end else begin
                        if (!MUL_REG) res_q <= mul_res;
                        state <= MUL_REG ? S_MUL : S_DONE;
                    end
                end
                S_MUL: begin
                    res_q <= mul_res;
                    state <= S_DONE;
                end
                S_DIV: if (div_done) begin
                    res_q <= div_res;
                    state <= S_DONE;
                end
                default: if (out_ready) state <= S_IDLE;
            endcase
        end
    end
endmodule
